pipo_rr_arbiter: RTL

Round-robin arbiter that shares one 4-bit parallel-in/parallel-out holding register between four requesters. It selects one requester per arbitration, captures that requester's word into the shared output register, pulses a one-hot grant, and holds the value for a programmable minimum number of cycles before re-arbitrating. It sits directly in front of the team's PIPO register datapath and replaces ad-hoc muxing of its `parallel_in`.

---
 rtl/pipo_rr_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter sharing one PIPO holding register among 4 requesters.
// Ports: clk, rst, req[3:0], data_in[4*WIDTH] -> grant, owner, parallel_out, out_valid, busy.
module pipo_rr_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data_in,
  output logic [3:0]         grant,
  output logic [1:0]         owner,
  output logic [WIDTH-1:0]   parallel_out,
  output logic               out_valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         grant_q, grant_d;
  logic [1:0]         owner_q, owner_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [1:0]         win;
  logic               hit;
  logic [WIDTH-1:0]   win_word;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        win = ptr_q + 2'(k);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    win_word = data_in[int'(win)*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    owner_d = owner_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          grant_d = 4'b0001 << win;
          owner_d = win;
          data_d  = win_word;
          valid_d = 1'b1;
          ptr_d   = win + 2'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy follows the state being entered so it is a clean register.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      owner_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign grant        = grant_q;
  assign owner        = owner_q;
  assign parallel_out = data_q;
  assign out_valid    = valid_q;
  assign busy         = busy_q;

endmodule
